// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I load/store unit: access sizes, funct3 encodings, LSU state encoding.
package riscv_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_WAIT   = 2'd2,
    LSU_RESP   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_extend.sv
// Load-data extension: the memory already lane-extracts and zero-extends, so only the
// signed forms need work here.
module riscv_lsu_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{data_i[7]}}, data_i[7:0]};
      F3_LH:   data_o = {{16{data_i[15]}}, data_i[15:0]};
      F3_LBU:  data_o = {24'd0, data_i[7:0]};
      F3_LHU:  data_o = {16'd0, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Single-outstanding RV32I load/store unit driving the riscv_memory data port.
// Build option: RISCV_LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] daddr_o,
  output logic [31:0]       dwdata_o,
  output logic [1:0]        dsize_o,
  output logic              drd_o,
  output logic              dwr_o,
  input  logic [31:0]       drdata_i
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              illegal;
  logic              req_fault;
  logic [ADDR_W-1:0] addr_lat;
  logic [31:0]       ext_data;

  riscv_lsu_extend u_extend (
    .funct3_i (f3_q),
    .data_i   (drdata_i),
    .data_o   (ext_data)
  );

  assign illegal = req_we_i ? (req_funct3_i >= 3'd3)
                            : ((req_funct3_i == 3'd3) || (req_funct3_i[2:1] == 2'b11));

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    case (req_funct3_i[1:0])
      SIZE_HALF: misalign = req_addr_i[0];
      SIZE_WORD: misalign = |req_addr_i[1:0];
      default:   misalign = 1'b0;
    endcase
  end
  assign req_fault = illegal | misalign;
  assign addr_lat  = req_addr_i;
`else
  // Misaligned requests are silently rounded down to the natural boundary.
  always_comb begin
    addr_lat = req_addr_i;
    case (req_funct3_i[1:0])
      SIZE_HALF: addr_lat = {req_addr_i[ADDR_W-1:1], 1'b0};
      SIZE_WORD: addr_lat = {req_addr_i[ADDR_W-1:2], 2'b00};
      default:   addr_lat = req_addr_i;
    endcase
  end
  assign req_fault = illegal;
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= LSU_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      tag_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      tag_q   <= tag_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    tag_d   = tag_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid_i) begin
          addr_d  = addr_lat;
          wdata_d = req_wdata_i;
          f3_d    = req_funct3_i;
          we_d    = req_we_i;
          tag_d   = req_tag_i;
          err_d   = req_fault;
          rdata_d = '0;
          state_d = req_fault ? LSU_RESP : LSU_ACCESS;
        end
      end
      LSU_ACCESS: state_d = we_q ? LSU_RESP : LSU_WAIT;
      // Read data is only valid during this one cycle; the lane changes afterwards.
      LSU_WAIT: begin
        rdata_d = ext_data;
        state_d = LSU_RESP;
      end
      LSU_RESP: if (rsp_ready_i) state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == LSU_IDLE);
    drd_o       = (state_q == LSU_ACCESS) && !we_q;
    dwr_o       = (state_q == LSU_ACCESS) && we_q;
    rsp_valid_o = (state_q == LSU_RESP);
  end

  assign daddr_o     = addr_q;
  assign dwdata_o    = wdata_q;
  assign dsize_o     = f3_q[1:0];
  assign rsp_rdata_o = rdata_q;
  assign rsp_tag_o   = tag_q;
  assign rsp_err_o   = err_q;

endmodule
